ksa_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on both sides.
//  One prefix level is computed per pipeline stage.

---
 rtl/ksa_if.sv | 24 ++
 rtl/ksa_pipe.sv | 102 ++++++++++
 tb/tb_ksa_pipe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_if.sv
// Streaming add/sub channel: operand side (in_*) and result side (out_*) of a ksa_pipe.
interface ksa_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per stage, global stall,
// registered outputs, results in order at one op per cycle.

module ksa_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);
  assign go = gi | (pi & gj);
  assign po = pi & pj;
endmodule

module ksa_pipe #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  ksa_if.slave bus
);
  localparam int L      = $clog2(WIDTH);
  localparam int STAGES = L + 1;

  logic [STAGES:0]          vld_pipe;
  logic                     stall;

  // Index 0 is the operand stage, index k holds prefix level k.
  logic [L:0][WIDTH-1:0]    g_n, p_n, p0_n;
  logic [L:0][WIDTH-1:0]    g_q, p_q, p0_q;
  logic [L:0]               c0_n, c0_q;

  logic [WIDTH-1:0]         b_eff;
  logic [WIDTH:0]           carry;
  logic [WIDTH-1:0]         sum_q;
  logic                     cout_q, ovf_q;

  assign stall         = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Subtract is a + ~b + 1; the +1 rides in as the carry into bit 0.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign g_n[0]  = bus.a & b_eff;
  assign p_n[0]  = bus.a ^ b_eff;
  assign p0_n[0] = bus.a ^ b_eff;
  assign c0_n[0] = bus.sub | bus.cin;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int SPAN = 1 << (k - 1);
    assign p0_n[k] = p0_q[k-1];
    assign c0_n[k] = c0_q[k-1];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        ksa_cell u_cell (
          .gi (g_q[k-1][i]),
          .pi (p_q[k-1][i]),
          .gj (g_q[k-1][i-SPAN]),
          .pj (p_q[k-1][i-SPAN]),
          .go (g_n[k][i]),
          .po (p_n[k][i])
        );
      end else begin : g_pass
        assign g_n[k][i] = g_q[k-1][i];
        assign p_n[k][i] = p_q[k-1][i];
      end
    end
  end

  // After L levels G/P span bits [i:0]; fold in the carry-in to get WIDTH+1 carries.
  assign carry[0] = c0_q[L];
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign carry[i+1] = g_q[L][i] | (p_q[L][i] & c0_q[L]);
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      g_q  <= g_n;
      p_q  <= p_n;
      p0_q <= p0_n;
      c0_q <= c0_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
      sum_q    <= p0_q[L] ^ carry[WIDTH-1:0];
      cout_q   <= carry[WIDTH];
      ovf_q    <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_ksa_pipe.sv
// Directed and randomized checks of ksa_pipe at WIDTH=16 and WIDTH=4.
module tb_ksa_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ksa_if #(.WIDTH(16)) i16 ();
  ksa_if #(.WIDTH(4))  i4 ();

  ksa_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
  ksa_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(i4));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Single op into an empty WIDTH=16 pipe; returns result and cycles to out_valid.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, output logic [15:0] s, output logic co,
                      output logic ov, output int lat);
    i16.a = a; i16.b = b; i16.cin = cin; i16.sub = sub;
    i16.in_valid = 1'b1; i16.out_ready = 1'b1;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    lat = 1;
    while (!i16.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    s = i16.sum; co = i16.cout; ov = i16.ovf;
    @(posedge clk); #1;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic sub, output logic [3:0] s, output logic co,
                     output logic ov, output int lat);
    i4.a = a; i4.b = b; i4.cin = cin; i4.sub = sub;
    i4.in_valid = 1'b1; i4.out_ready = 1'b1;
    @(posedge clk); #1;
    i4.in_valid = 1'b0;
    lat = 1;
    while (!i4.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    s = i4.sum; co = i4.cout; ov = i4.ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    i16.in_valid = 1'b1; i16.a = 16'h1111; i16.b = 16'h2222; i16.cin = 1'b0; i16.sub = 1'b0;
    i16.out_ready = 1'b1;
    i4.in_valid = 1'b1; i4.a = 4'h1; i4.b = 4'h2; i4.cin = 1'b0; i4.sub = 1'b0;
    i4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; i16.in_valid = 1'b0; i4.in_valid = 1'b0;
    checks++;
    if (i16.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", i16.out_valid);
    else passed++;
    checks++;
    if (i16.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", i16.in_ready);
    else passed++;
    checks++;
    if ({i16.cout, i16.ovf, i16.sum} !== 18'h0)
      $display("FAIL reset_outputs: got %h required 0", {i16.cout, i16.ovf, i16.sum});
    else passed++;
    checks++;
    if (i4.out_valid !== 1'b0 || i4.in_ready !== 1'b1)
      $display("FAIL reset_w4: got valid=%b ready=%b required 0/1", i4.out_valid, i4.in_ready);
    else passed++;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (i16.out_valid || i4.out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL reset_no_accept: got %0d outputs required 0", seen);
    else passed++;
  endtask

  task automatic test_add();
    logic [15:0] s; logic co, ov; int lat;
    op16(16'h0003, 16'h0005, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (lat != 6) $display("FAIL add_latency: got %0d required 6", lat); else passed++;
    checks++;
    if ({co, ov, s} !== {1'b0, 1'b0, 16'h0008})
      $display("FAIL add_3_5: got co=%b ov=%b s=%h required 0 0 0008", co, ov, s);
    else passed++;
    op16(16'h1234, 16'h0F0F, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if ({co, ov, s} !== {1'b0, 1'b0, 16'h2144})
      $display("FAIL add_cin: got co=%b ov=%b s=%h required 0 0 2144", co, ov, s);
    else passed++;
  endtask

  task automatic test_carry_ovf();
    logic [15:0] s; logic co, ov; int lat;
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({co, ov, s} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL add_wrap: got co=%b ov=%b s=%h required 1 0 0000", co, ov, s);
    else passed++;
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({co, ov, s} !== {1'b0, 1'b1, 16'h8000})
      $display("FAIL add_ovf: got co=%b ov=%b s=%h required 0 1 8000", co, ov, s);
    else passed++;
  endtask

  task automatic test_sub();
    logic [15:0] s; logic co, ov; int lat;
    op16(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat);
    checks++;
    if ({co, ov, s} !== {1'b0, 1'b0, 16'hFFFE})
      $display("FAIL sub_borrow: got co=%b ov=%b s=%h required 0 0 FFFE", co, ov, s);
    else passed++;
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if ({co, ov, s} !== {1'b1, 1'b1, 16'h7FFF})
      $display("FAIL sub_ovf: got co=%b ov=%b s=%h required 1 1 7FFF", co, ov, s);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, rcv = 0, cyc = 0, extra = 0;
    logic stall_win, fire;
    while (rcv < 10 && cyc < 60) begin
      stall_win = (cyc >= 8 && cyc <= 10);
      i16.out_ready = !stall_win;
      i16.in_valid  = (sent < 10);
      i16.a = 16'(sent); i16.b = 16'(sent); i16.cin = 1'b0; i16.sub = 1'b0;
      #1;
      checks++;
      if (i16.in_ready !== !stall_win)
        $display("FAIL b2b_in_ready cyc%0d: got %b required %b", cyc, i16.in_ready, !stall_win);
      else passed++;
      if (stall_win) begin
        checks++;
        if (i16.out_valid !== 1'b1 || i16.sum !== 16'(2*rcv))
          $display("FAIL b2b_hold cyc%0d: got v=%b s=%h required 1 %h", cyc, i16.out_valid,
                   i16.sum, 16'(2*rcv));
        else passed++;
      end else if (i16.out_valid) begin
        checks++;
        if (i16.sum !== 16'(2*rcv))
          $display("FAIL b2b_sum%0d: got %h required %h", rcv, i16.sum, 16'(2*rcv));
        else passed++;
        rcv++;
      end
      fire = i16.in_valid & i16.in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
      cyc++;
    end
    i16.in_valid = 1'b0; i16.out_ready = 1'b1;
    checks++;
    if (rcv != 10) $display("FAIL b2b_count: got %0d required 10", rcv); else passed++;
    repeat (6) begin
      if (i16.out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra != 0) $display("FAIL b2b_dup: got %0d extra results required 0", extra);
    else passed++;
  endtask

  task automatic test_flush();
    int seen = 0;
    i16.out_ready = 1'b1; i16.cin = 1'b0; i16.sub = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i16.in_valid = 1'b1; i16.a = 16'(i); i16.b = 16'h0100;
      @(posedge clk); #1;
    end
    rst = 1'b1; i16.a = 16'h1234;
    @(posedge clk); #1;
    rst = 1'b0; i16.in_valid = 1'b0;
    checks++;
    if (i16.out_valid !== 1'b0 || i16.in_ready !== 1'b1)
      $display("FAIL flush_state: got valid=%b ready=%b required 0/1", i16.out_valid, i16.in_ready);
    else passed++;
    repeat (10) begin
      @(posedge clk); #1;
      if (i16.out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL flush_stale: got %0d results required 0", seen); else passed++;
  endtask

  task automatic test_w4();
    logic [3:0] s; logic co, ov; int lat;
    op4(4'b1010, 4'b0101, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if (lat != 4) $display("FAIL w4_latency: got %0d required 4", lat); else passed++;
    checks++;
    if ({co, ov, s} !== {1'b1, 1'b0, 4'b0000})
      $display("FAIL w4_add: got co=%b ov=%b s=%b required 1 0 0000", co, ov, s);
    else passed++;
  endtask

  task automatic test_random4();
    logic [5:0] q[$];
    logic [5:0] exp;
    int pushed = 0, cyc = 0;
    while ((pushed < 2000 || q.size() > 0) && cyc < 20000) begin
      logic [3:0] ra, rb, bb;
      logic rc, rs, ro;
      logic [4:0] full;
      ra = 4'($urandom); rb = 4'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      i4.a = ra; i4.b = rb; i4.cin = rc; i4.sub = rs;
      i4.in_valid  = (pushed < 2000) && ($urandom_range(0, 3) != 0);
      i4.out_ready = ($urandom_range(0, 4) != 0);
      #1;
      if (i4.out_valid && i4.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rnd_unexpected: got %h required no result", {i4.cout, i4.ovf, i4.sum});
        end else begin
          exp = q.pop_front();
          if ({i4.cout, i4.ovf, i4.sum} !== exp)
            $display("FAIL rnd_result: got %h required %h", {i4.cout, i4.ovf, i4.sum}, exp);
          else passed++;
        end
      end
      if (i4.in_valid && i4.in_ready) begin
        bb   = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + {4'b0, (rs | rc)};
        ro   = (ra[3] == bb[3]) && (full[3] != ra[3]);
        q.push_back({full[4], ro, full[3:0]});
        pushed++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i4.in_valid = 1'b0; i4.out_ready = 1'b1;
    checks++;
    if (pushed != 2000 || q.size() != 0)
      $display("FAIL rnd_drain: got pushed=%0d pending=%0d required 2000/0", pushed, q.size());
    else passed++;
  endtask

  initial begin
    i16.in_valid = 1'b0; i16.out_ready = 1'b1; i16.a = '0; i16.b = '0; i16.cin = 1'b0; i16.sub = 1'b0;
    i4.in_valid  = 1'b0; i4.out_ready  = 1'b1; i4.a  = '0; i4.b  = '0; i4.cin  = 1'b0; i4.sub  = 1'b0;
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_back_to_back();
    test_flush();
    test_w4();
    test_random4();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
